jb_adc_sel_sched: RTL and testbench
===================================

Name: jb_adc_sel_sched

Overview:
- Time-division scheduler for the 8:1 ADC selection mux that feeds the DFE stream.
- Drives the mux select code and walks round-robin over a mask of enabled ADC channels.
- After each switch, discards samples for a settle window, then forwards a fixed dwell of samples from the registered mux output.
- Tags each forwarded sample with its channel index and marks the last sample of each dwell.

Parameters:
N_ADC, 8, number of selectable ADC channels
SEL_BW, 3, select/tag width, equals $clog2(N_ADC)
DWELL_BW, 16, width of dwell sample count
SETTLE_CYC, 3, valid samples discarded after each select change (covers mux retime register plus upstream pipe)

Ports:
axis_clk  in  1  stream clock
axis_areset  in  1  asynchronous active-high reset
cfg_en  in  1  level; 1 = run scheduler, 0 = abort to IDLE
cfg_mask  in  N_ADC  channel enable mask, bit n = ADC n
cfg_dwell  in  DWELL_BW  samples forwarded per channel visit (0 treated as 1)
cfg_oneshot  in  1  1 = stop after one full sweep
adc_sel  out  SEL_BW  select code to ADC mux
s_tvalid  in  1  mux output valid
s_tdata  in  32  mux output data {q,i}
m_tvalid  out  1  forwarded valid
m_tdata  out  32  forwarded data
m_tuser  out  SEL_BW  channel index of sample
m_tlast  out  1  last sample of the dwell
busy  out  1  state != IDLE and state != DONE
sweep_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset: adc_sel=0, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, busy=0, sweep_done=0, state=IDLE, last_ch=N_ADC-1 (so the first pick is the lowest enabled index).
- No backpressure: the source cannot stall, so m_* carry no tready.
- m_* are registered: latency is 1 cycle from s_* to m_*.
- States: IDLE, PICK, SETTLE, CAPTURE, DONE.
- IDLE: stay while cfg_en=0 or cfg_mask=0. Otherwise go to PICK.
- PICK (1 cycle): next_ch = first set mask bit strictly after last_ch, searching with wrap-around modulo N_ADC. adc_sel<=next_ch, last_ch<=next_ch. wrap flag = (next_ch is the highest set bit of cfg_mask). Clear settle and dwell counters. Go to SETTLE. cfg_mask and cfg_dwell are sampled only in PICK.
- SETTLE: count s_tvalid cycles. m_tvalid=0. After SETTLE_CYC valid samples, go to CAPTURE. SETTLE_CYC=0 skips directly to CAPTURE.
- CAPTURE: each s_tvalid cycle sets m_tvalid=1, m_tdata=s_tdata, m_tuser=adc_sel, and increments dwell_cnt.
- On sample number max(cfg_dwell,1): m_tlast=1 on that beat. Then:
  - if wrap flag: pulse sweep_done (aligned with the m_tlast beat); go to DONE if cfg_oneshot=1, else PICK.
  - if not wrap flag: go to PICK.
- Cycles with s_tvalid=0 produce m_tvalid=0 and no count.
- DONE: hold adc_sel. Return to IDLE only when cfg_en=0.
- cfg_en=0 in PICK, SETTLE or CAPTURE: IDLE next cycle. m_tvalid=0 from the following cycle. No m_tlast is issued for the truncated dwell. last_ch is retained.
- Mask with a single bit: that channel is re-picked every visit. Every visit is a wrap, and SETTLE still applies.
- cfg_mask bits at or above N_ADC do not exist. adc_sel never holds an unmasked channel during CAPTURE.

Optional Feature:
- Macro: JB_ADC_SCHED_STATS_EN.
- With macro defined:
  - extra output sweep_cnt [15:0] increments on each sweep_done and wraps 0xFFFF->0. Cleared only by reset.
  - extra output drop_cnt [15:0] counts s_tvalid cycles discarded in SETTLE, saturating at 0xFFFF.
- Without macro: both ports exist and are tied to 0, and no counter logic is built.

Test Plan:
- Mask=0x05, dwell=4, SETTLE_CYC=3, s_tvalid=1 always, oneshot=0 -> adc_sel 0,2,0,2...; each visit gives 3 dropped samples then 4 m_tvalid beats with m_tuser=visit channel and m_tlast on beat 4; sweep_done together with the channel-2 m_tlast.
- Mask=0xFF, dwell=1, oneshot=1 -> 8 single-beat dwells tagged 0..7, each with m_tlast=1; sweep_done once; busy=0 in DONE; cfg_en toggle 1->0->1 restarts at channel 0.
- s_tvalid asserted every 3rd cycle, mask=0x80, dwell=5 -> exactly 5 forwarded beats per visit, m_tdata equals s_tdata delayed 1 cycle, all tagged 7.
- cfg_en dropped on CAPTURE beat 2 of 4 -> m_tvalid=0 from the next cycle, no m_tlast; re-enable resumes at the channel after the aborted one.
- cfg_dwell=0, mask=0x10 -> behaves as dwell=1 on channel 4; mask=0 with cfg_en=1 -> remains IDLE, adc_sel unchanged.
- axis_areset asserted mid-CAPTURE -> all outputs go to 0 immediately (asynchronously); with JB_ADC_SCHED_STATS_EN, after 3 sweeps sweep_cnt=3 and drop_cnt=3*visits*SETTLE_CYC.

Source files
------------

// File: rtl/jb_adc_sel_sched_if.sv
// rtl/jb_adc_sel_sched_if.sv - config, mux-select and sample stream bundle for jb_adc_sel_sched
// master drives config and the mux-output stream; slave is the scheduler.
interface jb_adc_sel_sched_if #(
    parameter int N_ADC    = 8,
    parameter int SEL_BW   = $clog2(N_ADC),
    parameter int DWELL_BW = 16
);
    logic                cfg_en;
    logic [N_ADC-1:0]    cfg_mask;
    logic [DWELL_BW-1:0] cfg_dwell;
    logic                cfg_oneshot;
    logic [SEL_BW-1:0]   adc_sel;
    logic                s_tvalid;
    logic [31:0]         s_tdata;
    logic                m_tvalid;
    logic [31:0]         m_tdata;
    logic [SEL_BW-1:0]   m_tuser;
    logic                m_tlast;
    logic                busy;
    logic                sweep_done;
    logic [15:0]         sweep_cnt;
    logic [15:0]         drop_cnt;

    modport master (
        output cfg_en, cfg_mask, cfg_dwell, cfg_oneshot, s_tvalid, s_tdata,
        input  adc_sel, m_tvalid, m_tdata, m_tuser, m_tlast, busy, sweep_done,
               sweep_cnt, drop_cnt
    );

    modport slave (
        input  cfg_en, cfg_mask, cfg_dwell, cfg_oneshot, s_tvalid, s_tdata,
        output adc_sel, m_tvalid, m_tdata, m_tuser, m_tlast, busy, sweep_done,
               sweep_cnt, drop_cnt
    );
endinterface

// File: rtl/jb_adc_sel_sched.sv
// rtl/jb_adc_sel_sched.sv - round-robin ADC mux select scheduler with settle/dwell framing
// Optional sweep/drop statistics counters enabled by JB_ADC_SCHED_STATS_EN.
module jb_adc_sel_sched #(
    parameter int N_ADC      = 8,
    parameter int SEL_BW     = $clog2(N_ADC),
    parameter int DWELL_BW   = 16,
    parameter int SETTLE_CYC = 3
) (
    input  logic               axis_clk,
    input  logic               axis_areset,
    jb_adc_sel_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PICK, ST_SETTLE, ST_CAPTURE, ST_DONE
    } state_t;

    localparam int ST_BW = $clog2(SETTLE_CYC + 2);

    state_t              r_state;
    logic [SEL_BW-1:0]   r_last_ch;
    logic [SEL_BW-1:0]   r_adc_sel;
    logic                r_wrap;
    logic [ST_BW-1:0]    r_settle_cnt;
    logic [DWELL_BW-1:0] r_dwell_cnt;
    logic [DWELL_BW-1:0] r_dwell_tgt;
    logic                r_m_tvalid;
    logic [31:0]         r_m_tdata;
    logic [SEL_BW-1:0]   r_m_tuser;
    logic                r_m_tlast;
    logic                r_sweep_done;

    logic [SEL_BW-1:0]   w_next_ch;
    logic [SEL_BW-1:0]   w_hi_ch;
    logic                w_found;
    logic                w_cap_beat;
    logic                w_dwell_end;
    logic                w_drop_beat;

    // Next channel: first enabled bit strictly after last_ch, wrapping around.
    always_comb begin
        int w_idx;
        w_idx     = 0;
        w_next_ch = r_last_ch;
        w_found   = 1'b0;
        w_hi_ch   = '0;
        for (int i = 0; i < N_ADC; i++) begin
            if (bus.cfg_mask[i]) w_hi_ch = SEL_BW'(i);
        end
        for (int i = 1; i <= N_ADC; i++) begin
            w_idx = (int'(r_last_ch) + i) % N_ADC;
            if (!w_found && bus.cfg_mask[SEL_BW'(w_idx)]) begin
                w_next_ch = SEL_BW'(w_idx);
                w_found   = 1'b1;
            end
        end
    end

    assign w_cap_beat  = (r_state == ST_CAPTURE) && bus.cfg_en && bus.s_tvalid;
    assign w_dwell_end = w_cap_beat && (r_dwell_cnt == r_dwell_tgt - DWELL_BW'(1));
    assign w_drop_beat = (r_state == ST_SETTLE) && bus.cfg_en && bus.s_tvalid;

    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state      <= ST_IDLE;
            r_last_ch    <= SEL_BW'(N_ADC - 1);
            r_adc_sel    <= '0;
            r_wrap       <= 1'b0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
            r_dwell_tgt  <= DWELL_BW'(1);
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tuser    <= '0;
            r_m_tlast    <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_sweep_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_en && (|bus.cfg_mask)) r_state <= ST_PICK;
                end
                ST_PICK: begin
                    // An empty mask here means it was cleared mid-run; park rather than select a dead channel.
                    if (!bus.cfg_en || !w_found) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_adc_sel    <= w_next_ch;
                        r_last_ch    <= w_next_ch;
                        r_wrap       <= (w_next_ch == w_hi_ch);
                        r_settle_cnt <= '0;
                        r_dwell_cnt  <= '0;
                        r_dwell_tgt  <= (bus.cfg_dwell == '0) ? DWELL_BW'(1) : bus.cfg_dwell;
                        r_state      <= (SETTLE_CYC == 0) ? ST_CAPTURE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.cfg_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_drop_beat) begin
                        r_settle_cnt <= r_settle_cnt + ST_BW'(1);
                        if (r_settle_cnt == ST_BW'(SETTLE_CYC - 1)) r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.cfg_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_cap_beat) begin
                        r_m_tvalid  <= 1'b1;
                        r_m_tdata   <= bus.s_tdata;
                        r_m_tuser   <= r_adc_sel;
                        r_dwell_cnt <= r_dwell_cnt + DWELL_BW'(1);
                        if (w_dwell_end) begin
                            r_m_tlast <= 1'b1;
                            if (r_wrap) begin
                                r_sweep_done <= 1'b1;
                                r_state      <= bus.cfg_oneshot ? ST_DONE : ST_PICK;
                            end else begin
                                r_state <= ST_PICK;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.cfg_en) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.adc_sel    = r_adc_sel;
    assign bus.m_tvalid   = r_m_tvalid;
    assign bus.m_tdata    = r_m_tdata;
    assign bus.m_tuser    = r_m_tuser;
    assign bus.m_tlast    = r_m_tlast;
    assign bus.sweep_done = r_sweep_done;
    assign bus.busy       = (r_state == ST_PICK) || (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);

`ifdef JB_ADC_SCHED_STATS_EN
    logic [15:0] r_sweep_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            r_sweep_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_dwell_end && r_wrap) r_sweep_cnt <= r_sweep_cnt + 16'd1;
            if (w_drop_beat && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.sweep_cnt = r_sweep_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
`else
    assign bus.sweep_cnt = 16'h0;
    assign bus.drop_cnt  = 16'h0;
`endif
endmodule

// File: tb/tb_jb_adc_sel_sched.sv
// tb/tb_jb_adc_sel_sched.sv - randomized scenario bench for jb_adc_sel_sched against a visit-level model
module tb_jb_adc_sel_sched;
    localparam int N_ADC    = 8;
    localparam int SEL_BW   = 3;
    localparam int DWELL_BW = 16;
    localparam int SETTLE   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jb_adc_sel_sched_if #(.N_ADC(N_ADC), .SEL_BW(SEL_BW), .DWELL_BW(DWELL_BW)) ifc ();

    jb_adc_sel_sched #(
        .N_ADC(N_ADC), .SEL_BW(SEL_BW), .DWELL_BW(DWELL_BW), .SETTLE_CYC(SETTLE)
    ) dut (
        .axis_clk   (clk),
        .axis_areset(rst),
        .bus        (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a visit = pick cycle, SETTLE dropped valid samples, then dwell forwarded samples.
    bit          md_active, md_pick, md_done, md_wrap;
    int          md_k, md_last, md_ch, md_d, md_sweeps, md_drops;
    logic [2:0]  e_sel, e_user;
    logic [31:0] e_data;
    bit          e_v, e_last, e_sweep;

    function automatic int next_enabled(input logic [7:0] mask, input int last);
        for (int i = 1; i <= N_ADC; i++)
            if (mask[(last + i) % N_ADC]) return (last + i) % N_ADC;
        return last;
    endfunction

    function automatic int highest_enabled(input logic [7:0] mask);
        int h = 0;
        for (int i = 0; i < N_ADC; i++) if (mask[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        md_active = 0; md_pick = 0; md_done = 0; md_wrap = 0;
        md_k = 0; md_last = N_ADC - 1; md_ch = 0; md_d = 1; md_sweeps = 0; md_drops = 0;
        e_sel = 0; e_user = 0; e_data = 0; e_v = 0; e_last = 0; e_sweep = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input logic [31:0] d);
        e_v = 0; e_last = 0; e_sweep = 0;
        if (md_done) begin
            if (!en) md_done = 0;
        end else if (!md_active) begin
            if (en && ifc.cfg_mask != 0) begin md_active = 1; md_pick = 1; end
        end else if (!en) begin
            md_active = 0; md_pick = 0;
        end else if (md_pick) begin
            md_ch   = next_enabled(ifc.cfg_mask, md_last);
            md_last = md_ch;
            e_sel   = 3'(md_ch);
            md_d    = (ifc.cfg_dwell == 0) ? 1 : int'(ifc.cfg_dwell);
            md_wrap = (md_ch == highest_enabled(ifc.cfg_mask));
            md_k    = 0;
            md_pick = 0;
        end else if (v) begin
            if (md_k < SETTLE) begin
                md_drops++;
            end else begin
                e_v = 1; e_data = d; e_user = 3'(md_ch);
                if (md_k - SETTLE == md_d - 1) begin
                    e_last  = 1;
                    md_pick = 1;
                    if (md_wrap) begin
                        e_sweep = 1;
                        md_sweeps++;
                        if (ifc.cfg_oneshot) begin md_active = 0; md_done = 1; md_pick = 0; end
                    end
                end
            end
            md_k++;
        end
    endtask

    function automatic logic [41:0] obs_vec();
        return {ifc.busy, ifc.adc_sel, ifc.m_tvalid, ifc.m_tdata, ifc.m_tuser, ifc.m_tlast, ifc.sweep_done};
    endfunction

    function automatic logic [41:0] exp_vec();
        return {md_active, e_sel, e_v, e_data, e_user, e_last, e_sweep};
    endfunction

    task automatic step(input bit en, input bit v, input logic [31:0] d);
        ifc.cfg_en = en; ifc.s_tvalid = v; ifc.s_tdata = d;
        @(posedge clk);
        model_edge(en, v, d);
        #1;
    endtask

    task automatic do_reset();
        ifc.cfg_en = 0; ifc.s_tvalid = 0; ifc.s_tdata = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs_vec() !== 42'h0) $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 42'h0);
        else n_pass++;
        n_checks++;
        if ({ifc.sweep_cnt, ifc.drop_cnt} !== 32'h0)
            $display("FAIL reset_stats got=%h exp=%h", {ifc.sweep_cnt, ifc.drop_cnt}, 32'h0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int n_last = 0, n_sweep = 0;
        do_reset();
        ifc.cfg_mask = 8'h05; ifc.cfg_dwell = 16'd4; ifc.cfg_oneshot = 0;
        for (int c = 0; c < 80; c++) begin
            step(1, 1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rr_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (ifc.m_tvalid && ifc.m_tlast) n_last++;
            if (ifc.sweep_done) begin
                n_sweep++;
                n_checks++;
                if ({ifc.m_tlast, ifc.m_tuser} !== {1'b1, 3'd2})
                    $display("FAIL rr_sweep_align got=%h exp=%h", {ifc.m_tlast, ifc.m_tuser}, {1'b1, 3'd2});
                else n_pass++;
            end
        end
        n_checks++;
        if (n_last !== 9 || n_sweep !== 4) $display("FAIL rr_counts got=%0d/%0d exp=9/4", n_last, n_sweep);
        else n_pass++;
    endtask

    task automatic test_full_oneshot();
        int tags[$];
        int n_sweep = 0;
        do_reset();
        ifc.cfg_mask = 8'hFF; ifc.cfg_dwell = 16'd1; ifc.cfg_oneshot = 1;
        for (int c = 0; c < 60; c++) begin
            step(1, 1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL oneshot_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (ifc.m_tvalid) begin
                tags.push_back(int'(ifc.m_tuser));
                n_checks++;
                if (ifc.m_tlast !== 1'b1) $display("FAIL oneshot_tlast got=%b exp=1", ifc.m_tlast);
                else n_pass++;
            end
            if (ifc.sweep_done) n_sweep++;
        end
        n_checks++;
        if (tags.size() != 8) $display("FAIL oneshot_beats got=%0d exp=8", tags.size());
        else n_pass++;
        for (int i = 0; i < tags.size() && i < 8; i++) begin
            n_checks++;
            if (tags[i] != i) $display("FAIL oneshot_tag i=%0d got=%0d exp=%0d", i, tags[i], i);
            else n_pass++;
        end
        n_checks++;
        if (n_sweep != 1 || ifc.busy !== 1'b0) $display("FAIL oneshot_done got=%0d/%b exp=1/0", n_sweep, ifc.busy);
        else n_pass++;
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        n_checks++;
        if (ifc.adc_sel !== 3'd0 || ifc.busy !== 1'b1)
            $display("FAIL oneshot_restart got=%0d/%b exp=0/1", ifc.adc_sel, ifc.busy);
        else n_pass++;
    endtask

    task automatic test_sparse_valid();
        int since = 0, n_last = 0;
        do_reset();
        ifc.cfg_mask = 8'h80; ifc.cfg_dwell = 16'd5; ifc.cfg_oneshot = 0;
        for (int c = 0; c < 120; c++) begin
            step(1, (c % 3) == 0, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL sparse_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (ifc.m_tvalid) begin
                since++;
                if (ifc.m_tlast) begin
                    n_last++;
                    n_checks++;
                    if (since != 5 || ifc.m_tuser !== 3'd7)
                        $display("FAIL sparse_visit got=%0d/%0d exp=5/7", since, ifc.m_tuser);
                    else n_pass++;
                    since = 0;
                end
            end
        end
        n_checks++;
        if (n_last < 2) $display("FAIL sparse_visits got=%0d exp>=2", n_last);
        else n_pass++;
    endtask

    task automatic test_abort();
        int beats = 0;
        do_reset();
        ifc.cfg_mask = 8'h05; ifc.cfg_dwell = 16'd4; ifc.cfg_oneshot = 0;
        for (int c = 0; c < 40 && beats < 2; c++) begin
            step(1, 1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL abort_pre c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (ifc.m_tvalid) beats++;
        end
        n_checks++;
        if (beats != 2) $display("FAIL abort_wait got=%0d exp=2", beats);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step(0, 1, $urandom);
            n_checks++;
            if ({ifc.m_tvalid, ifc.m_tlast, ifc.busy} !== 3'b000 || obs_vec() !== exp_vec())
                $display("FAIL abort_quiet c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
        end
        step(1, 1, $urandom);
        step(1, 1, $urandom);
        n_checks++;
        if (ifc.adc_sel !== 3'd2) $display("FAIL abort_resume got=%0d exp=2", ifc.adc_sel);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            step(1, 1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL abort_post c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_dwell0_mask0();
        do_reset();
        ifc.cfg_mask = 8'h10; ifc.cfg_dwell = 16'd0; ifc.cfg_oneshot = 0;
        for (int c = 0; c < 40; c++) begin
            step(1, 1'($urandom), $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL dwell0_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            if (ifc.m_tvalid) begin
                n_checks++;
                if ({ifc.m_tlast, ifc.m_tuser} !== {1'b1, 3'd4})
                    $display("FAIL dwell0_beat got=%h exp=%h", {ifc.m_tlast, ifc.m_tuser}, {1'b1, 3'd4});
                else n_pass++;
            end
        end
        step(0, 0, 0);
        ifc.cfg_mask = 8'h00;
        for (int c = 0; c < 20; c++) begin
            step(1, 1, $urandom);
            n_checks++;
            if ({ifc.busy, ifc.adc_sel, ifc.m_tvalid} !== {1'b0, 3'd4, 1'b0} || obs_vec() !== exp_vec())
                $display("FAIL mask0_idle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset();
        ifc.cfg_mask = 8'h05; ifc.cfg_dwell = 16'd4; ifc.cfg_oneshot = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step(1, 1, $urandom | 32'h1);
            if (ifc.m_tvalid) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL areset_wait got=0 exp=1");
        else n_pass++;
        #2 rst = 1;
        #1;
        n_checks++;
        if (obs_vec() !== 42'h0 || {ifc.sweep_cnt, ifc.drop_cnt} !== 32'h0)
            $display("FAIL areset_outputs got=%h exp=%h", obs_vec(), 42'h0);
        else n_pass++;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_stats();
        int c = 0;
        do_reset();
        ifc.cfg_mask = 8'h05; ifc.cfg_dwell = 16'd2; ifc.cfg_oneshot = 0;
        while (md_sweeps < 3 && c < 200) begin
            step(1, 1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL stats_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else n_pass++;
            c++;
        end
        n_checks++;
`ifdef JB_ADC_SCHED_STATS_EN
        if (ifc.sweep_cnt !== 16'd3 || ifc.drop_cnt !== 16'(3 * 2 * SETTLE))
            $display("FAIL stats_counts got=%0d/%0d exp=3/%0d", ifc.sweep_cnt, ifc.drop_cnt, 3 * 2 * SETTLE);
        else n_pass++;
`else
        if (ifc.sweep_cnt !== 16'd0 || ifc.drop_cnt !== 16'd0)
            $display("FAIL stats_tied got=%0d/%0d exp=0/0", ifc.sweep_cnt, ifc.drop_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        ifc.cfg_en = 0; ifc.cfg_mask = 0; ifc.cfg_dwell = 0; ifc.cfg_oneshot = 0;
        ifc.s_tvalid = 0; ifc.s_tdata = 0;
        model_reset();
        test_reset();
        test_round_robin();
        test_full_oneshot();
        test_sparse_valid();
        test_abort();
        test_dwell0_mask0();
        test_async_reset();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
